ahb3lite_sram_slave: RTL and testbench

//  AHB3-Lite single-slave, zero-wait-state on-chip memory (MEM_DEPTH words of MEM_SIZE bits).

---
 rtl/ahb3lite_sram_slave.sv | 143 ++++++++++++++
 tb/tb_ahb3lite_sram_slave.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite zero-wait-state on-chip SRAM slave with byte/halfword/word access.
// Illegal transfers (bad size, misaligned, out of range) get a two-cycle ERROR response.
module ahb3lite_sram_slave #(
  parameter int MEM_SIZE   = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int IW = HADDR_SIZE - 2;
  localparam logic [IW-1:0] DEPTH_L = IW'(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                hreadyout_q, hreadyout_d;
  logic                hresp_q, hresp_d;
  logic                valid_q, valid_d;
  logic                write_q, write_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [3:0]          be_q, be_d;
  logic [MEM_SIZE-1:0] mem_q [MEM_DEPTH];

  logic       accept_s;
  logic       align_ok_s;
  logic       legal_s;
  logic [3:0] be_s;
  logic       unused_s;

  assign unused_s = ^{HBURST, HPROT, HTRANS[0]};

  // Address-phase decode: acceptance, legality and byte-lane enables
  always_comb begin
    accept_s = HSEL & HREADY & HTRANS[1];
    case (HSIZE)
      3'd0: begin
        align_ok_s = 1'b1;
        be_s       = 4'b0001 << HADDR[1:0];
      end
      3'd1: begin
        align_ok_s = ~HADDR[0];
        be_s       = HADDR[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        align_ok_s = (HADDR[1:0] == 2'b00);
        be_s       = 4'b1111;
      end
      default: begin
        align_ok_s = 1'b0;
        be_s       = 4'b0000;
      end
    endcase
    legal_s = align_ok_s & (HADDR[HADDR_SIZE-1:2] < DEPTH_L);
  end

  // Next-state and next-output logic of the response FSM
  always_comb begin
    state_d     = ST_OK;
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    valid_d     = 1'b0;
    write_d     = 1'b0;
    idx_d       = idx_q;
    be_d        = 4'b0000;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
      hresp_d = 1'b1;
    end else if (accept_s && legal_s) begin
      valid_d = 1'b1;
      write_d = HWRITE;
      idx_d   = HADDR[AW+1:2];
      be_d    = be_s;
    end else if (accept_s) begin
      state_d     = ST_ERR1;
      hreadyout_d = 1'b0;
      hresp_d     = 1'b1;
    end else begin
      state_d = ST_OK;
    end
  end

  // FSM state, registered response outputs and captured address phase
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= ST_OK;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      valid_q     <= 1'b0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      be_q        <= 4'b0000;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      valid_q     <= valid_d;
      write_q     <= write_d;
      idx_q       <= idx_d;
      be_q        <= be_d;
    end
  end

  // Storage: cleared on reset, lane-masked write at the end of a write data phase
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (valid_q && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  // Read data is combinational from the registered word index so a read right after a write sees it
  assign HRDATA    = (valid_q && !write_q) ? mem_q[idx_q] : '0;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench for ahb3lite_sram_slave: per-cycle compare against a transfer-level
// memory model, plus literal expectations on key read-backs and error responses.
module tb_ahb3lite_sram_slave;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahb3lite_sram_slave #(
    .MEM_SIZE(32), .MEM_DEPTH(256), .HADDR_SIZE(32), .HDATA_SIZE(32)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  // ---------------- transfer-level model ----------------
  logic [31:0] m_mem [256];
  bit          m_pend_wr;
  logic [7:0]  m_widx;
  logic [1:0]  m_waddr;
  logic [2:0]  m_wsize;
  int          m_err_phase;
  bit          m_acc;
  logic        exp_ready;
  logic        exp_resp;
  logic [31:0] exp_rdata;

  function automatic bit legal(input logic [31:0] a, input logic [2:0] s);
    int unsigned sz;
    sz = 32'(s);
    if (sz > 2) return 1'b0;
    if ((a % (32'd1 << sz)) != 32'd0) return 1'b0;
    return (a / 32'd4) < 32'd256;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] a, input logic [2:0] s);
    logic [31:0] mask;
    mask = (s == 3'd0) ? 32'h0000_00FF : (s == 3'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    mask = mask << (8 * a);
    return (old & ~mask) | (wd & mask);
  endfunction

  initial begin : model
    forever begin
      @(posedge HCLK);
      if (!HRESETn) begin
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
        m_pend_wr = 1'b0; m_err_phase = 0;
        exp_ready = 1'b1; exp_resp = 1'b0; exp_rdata = 32'h0;
      end else begin
        m_acc = HSEL && exp_ready && HTRANS[1];
        if (m_pend_wr) m_mem[m_widx] = merge(m_mem[m_widx], HWDATA, m_waddr, m_wsize);
        m_pend_wr = 1'b0;
        exp_ready = 1'b1; exp_resp = 1'b0; exp_rdata = 32'h0;
        if (m_err_phase == 1) begin
          m_err_phase = 2; exp_resp = 1'b1;
        end else if (m_acc && legal(HADDR, HSIZE)) begin
          m_err_phase = 0;
          if (HWRITE) begin
            m_pend_wr = 1'b1; m_widx = HADDR[9:2]; m_waddr = HADDR[1:0]; m_wsize = HSIZE;
          end else begin
            exp_rdata = m_mem[HADDR[9:2]];
          end
        end else if (m_acc) begin
          m_err_phase = 1; exp_ready = 1'b0; exp_resp = 1'b1;
        end else begin
          m_err_phase = 0;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge HCLK);
      if (chk_en) begin
        n_vec = n_vec + 3;
        if (HREADYOUT !== exp_ready) begin
          n_err++; $display("FAIL cyc_hreadyout t=%0t got=%b want=%b", $time, HREADYOUT, exp_ready);
        end
        if (HRESP !== exp_resp) begin
          n_err++; $display("FAIL cyc_hresp t=%0t got=%b want=%b", $time, HRESP, exp_resp);
        end
        if (HRDATA !== exp_rdata) begin
          n_err++; $display("FAIL cyc_hrdata t=%0t got=%h want=%h", $time, HRDATA, exp_rdata);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    @(negedge HCLK);
    HSEL = sel; HTRANS = tr; HWRITE = wr; HSIZE = sz; HADDR = a; HWDATA = wd;
    #1;
  endtask

  task automatic idle(input logic [31:0] wd);
    cyc(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, wd);
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = T_IDLE; HWRITE = 1'b0;
    @(posedge HCLK);
    chk_en = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
  endtask

  task automatic expect_out(input string name, input logic rdy, input logic rsp,
                            input logic [31:0] rd);
    n_vec++;
    if (HREADYOUT !== rdy || HRESP !== rsp || HRDATA !== rd) begin
      n_err++;
      $display("FAIL %s got rdy=%b resp=%b rdata=%h want rdy=%b resp=%b rdata=%h",
               name, HREADYOUT, HRESP, HRDATA, rdy, rsp, rd);
    end
  endtask

  task automatic word_write(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, T_NSEQ, 1'b1, 3'd2, a, 32'h0);
    idle(d);
  endtask

  task automatic word_read_check(input string name, input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, T_NSEQ, 1'b0, 3'd2, a, 32'h0);
    idle(32'h0);
    expect_out(name, 1'b1, 1'b0, d);
  endtask

  task automatic illegal_write(input string name, input logic [31:0] a, input logic [2:0] sz);
    cyc(1'b1, T_NSEQ, 1'b1, sz, a, 32'h0);
    idle(32'hFFFF_FFFF);
    expect_out({name, "_err1"}, 1'b0, 1'b1, 32'h0);
    idle(32'hFFFF_FFFF);
    expect_out({name, "_err2"}, 1'b1, 1'b1, 32'h0);
    idle(32'h0);
    expect_out({name, "_ok"}, 1'b1, 1'b0, 32'h0);
  endtask

  logic [31:0] burst_d [4];

  initial begin : stim
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'h0; HWDATA = 32'h0; HWRITE = 1'b0;
    HSIZE = 3'd0; HBURST = 3'd0; HPROT = 4'b0011; HTRANS = T_IDLE;
    burst_d[0] = 32'hA0A0_0001; burst_d[1] = 32'hB1B1_0002;
    burst_d[2] = 32'hC2C2_0003; burst_d[3] = 32'hD3D3_0004;

    do_reset();
    expect_out("reset_outputs", 1'b1, 1'b0, 32'h0);
    word_read_check("reset_read_0x10", 32'h10, 32'h0);

    // word write then back-to-back read of the same address
    cyc(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h04, 32'h0);
    cyc(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h04, 32'hDEAD_BEEF);
    expect_out("wr_dataphase_okay", 1'b1, 1'b0, 32'h0);
    idle(32'h0);
    expect_out("b2b_read_deadbeef", 1'b1, 1'b0, 32'hDEAD_BEEF);

    // byte and halfword lane writes with junk on the unselected lanes
    word_write(32'h04, 32'h1122_3344);
    cyc(1'b1, T_NSEQ, 1'b1, 3'd0, 32'h05, 32'h0);
    idle(32'h7766_AA55);
    word_read_check("byte_lane1", 32'h04, 32'h1122_AA44);
    cyc(1'b1, T_NSEQ, 1'b1, 3'd1, 32'h06, 32'h0);
    idle(32'h5566_9988);
    word_read_check("half_upper", 32'h04, 32'h5566_AA44);

    // INCR4 pipelined writes then reads
    HBURST = 3'b011;
    cyc(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h20, 32'h0);
    for (int i = 1; i < 4; i++) begin
      cyc(1'b1, T_SEQ, 1'b1, 3'd2, 32'h20 + 32'(4 * i), burst_d[i-1]);
      expect_out("incr4_wr_ready", 1'b1, 1'b0, 32'h0);
    end
    idle(burst_d[3]);
    cyc(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h20, 32'h0);
    for (int i = 1; i < 4; i++) begin
      cyc(1'b1, T_SEQ, 1'b0, 3'd2, 32'h20 + 32'(4 * i), 32'h0);
      expect_out("incr4_rd_beat", 1'b1, 1'b0, burst_d[i-1]);
    end
    idle(32'h0);
    expect_out("incr4_rd_beat3", 1'b1, 1'b0, burst_d[3]);
    HBURST = 3'b000;

    // illegal accesses leave the target word alone
    word_write(32'h00, 32'hCAFE_F00D);
    illegal_write("misaligned_word", 32'h02, 3'd2);
    illegal_write("hsize3", 32'h00, 3'd3);
    illegal_write("out_of_range", 32'h400, 3'd2);
    word_read_check("after_illegal", 32'h00, 32'hCAFE_F00D);

    // address ignored during ERR1, accepted during ERR2
    cyc(1'b1, T_NSEQ, 1'b0, 3'd1, 32'h01, 32'h0);
    cyc(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h04, 32'h0);
    expect_out("err1_phase", 1'b0, 1'b1, 32'h0);
    cyc(1'b1, T_NSEQ, 1'b0, 3'd2, 32'h00, 32'h0);
    expect_out("err2_ignored_read", 1'b1, 1'b1, 32'h0);
    idle(32'h0);
    expect_out("err2_accepted_read", 1'b1, 1'b0, 32'hCAFE_F00D);

    // IDLE, BUSY with HSEL=1 and NONSEQ with HSEL=0: no transfer
    cyc(1'b1, T_IDLE, 1'b1, 3'd2, 32'h20, 32'h0);
    cyc(1'b1, T_BUSY, 1'b1, 3'd2, 32'h20, 32'h1111_1111);
    expect_out("idle_okay", 1'b1, 1'b0, 32'h0);
    cyc(1'b0, T_NSEQ, 1'b1, 3'd2, 32'h20, 32'h2222_2222);
    expect_out("busy_okay", 1'b1, 1'b0, 32'h0);
    idle(32'h3333_3333);
    expect_out("nosel_okay", 1'b1, 1'b0, 32'h0);
    word_read_check("no_transfer_mem", 32'h20, burst_d[0]);

    // reset during an error response and during a write data phase
    cyc(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h03, 32'h0);
    do_reset();
    expect_out("reset_mid_error", 1'b1, 1'b0, 32'h0);
    cyc(1'b1, T_NSEQ, 1'b1, 3'd2, 32'h24, 32'h0);
    HWDATA = 32'h5A5A_5A5A;
    do_reset();
    expect_out("reset_mid_write", 1'b1, 1'b0, 32'h0);
    word_read_check("reset_cleared_0x24", 32'h24, 32'h0);
    word_read_check("reset_cleared_0x04", 32'h04, 32'h0);

    idle(32'h0);
    idle(32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
